rice_core_hazard_controller: RTL and testbench
==============================================

Name: rice_core_hazard_controller

Overview:
- Pipeline sequencing controller for the core; generates `stall` and `flush` for the IF/ID/EX stages and the fetch redirect.
- Keeps a per-register scoreboard of in-flight destination writes and stalls decode on RAW hazards.
- Sequences a multi-cycle flush on taken branches/jumps.
- Holds the pipeline flushed while the core is disabled.

Parameters:
- XLEN, 32, data/PC width.
- FLUSH_CYCLES, 2, cycles `o_flush` stays high after a redirect (legal range 1..15).
- PEND_W, 2, width of each scoreboard counter; max in-flight writes per register = 2^PEND_W-1.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset
- i_enable  input  1  core run enable
- i_issue_valid  input  1  ID stage holds a valid decoded instruction
- i_issue_rs1  input  5  source register 1 (0 = unused)
- i_issue_rs2  input  5  source register 2 (0 = unused)
- i_issue_rd  input  5  destination register (0 = no write)
- i_retire_valid  input  1  an instruction leaves writeback; killed instructions also retire
- i_retire_rd  input  5  destination of the retiring instruction
- i_branch_valid  input  1  EX resolved a taken branch/jump
- i_branch_target  input  XLEN  redirect PC
- o_stall  output  1  hold IF/ID, insert bubble into EX
- o_flush  output  1  clear IF/ID/EX valid bits
- o_redirect_valid  output  1  one-cycle fetch redirect strobe
- o_redirect_pc  output  XLEN  redirect PC
- o_busy  output  1  any scoreboard counter non-zero

Behaviour:
- Reset: i_rst_n asynchronous, active-low; clock i_clk. Reset values:
  - state = IDLE
  - all counters 0
  - o_flush = 1, o_stall = 0, o_redirect_valid = 0, o_redirect_pc = 0, o_busy = 0
- States: IDLE, RUN, FLUSH. Registered flush counter fcnt (4 bits).
- IDLE: o_flush = 1, o_stall = 0. Moves to RUN the cycle after i_enable = 1 is sampled.
- RUN:
  - o_flush = 0.
  - i_enable = 0 -> IDLE next cycle. Disable takes priority over a branch in the same cycle; that branch is dropped.
  - i_branch_valid = 1 -> FLUSH next cycle, with o_redirect_pc <= i_branch_target and fcnt <= FLUSH_CYCLES-1.
- FLUSH:
  - o_flush = 1.
  - o_redirect_valid = 1 only in the first FLUSH cycle; o_redirect_pc holds its value.
  - fcnt decrements each cycle; at fcnt = 0 -> RUN (or IDLE if i_enable = 0).
  - i_branch_valid is ignored (it comes from a killed instruction).
  - Total o_flush-high cycles = FLUSH_CYCLES.
- Hazard stall (combinational from registered counters and issue inputs):
  - o_stall = RUN & i_issue_valid & ( (rs1 != 0 & pend[rs1] != 0) | (rs2 != 0 & pend[rs2] != 0) | (rd != 0 & pend[rd] == max) ).
  - o_stall = 0 in IDLE and FLUSH.
  - Retire of a register in the same cycle does not release the stall; the stall drops the following cycle.
- Issue accept = RUN & i_issue_valid & !o_stall & !i_branch_valid.
  - On accept with rd != 0: pend[rd] += 1.
  - No increment in IDLE or FLUSH, or when rd = 0.
- Retire: i_retire_valid & rd != 0 -> pend[rd] -= 1. This is processed in every state, because in-flight instructions drain during IDLE and FLUSH.
- Simultaneous accept and retire on the same rd: net counter change 0.
- Retire to a counter already at 0: ignored; the counter stays 0 (no wrap). This is a verification assertion failure.
- Counters saturate: they never exceed max, guaranteed by the rd-full stall.
- o_busy = OR of all counters, registered (one cycle after the counter update).
- Latency: stall is same-cycle; flush starts the cycle after i_branch_valid; redirect strobe is concurrent with the first flush cycle.
- Reset mid-FLUSH or with counters non-zero: everything returns to the reset values immediately.

Test Plan:
- Reset, then i_enable = 1 -> o_flush stays 1 through the enable cycle; o_flush = 0 from the next cycle; o_busy = 0.
- Issue rd = 5 (accepted); next cycle issue rs1 = 5 -> o_stall = 1. Retire rd = 5 -> o_stall = 0 one cycle later; instruction accepted.
- i_branch_valid with target 0x0000_0100 and FLUSH_CYCLES = 2 -> o_flush = 1 for exactly 2 cycles; o_redirect_valid = 1 only in the first; o_redirect_pc = 0x100. A second branch during FLUSH is ignored.
- Issue rd = 3 three times (PEND_W = 2) -> pend[3] = 3; a fourth issue with rd = 3 stalls. Simultaneous issue and retire of rd = 3 at pend = 2 -> pend stays 2.
- Hazards on x0: rs1 = 0/rd = 0 -> never stall, no counter change. Retire rd = 7 with pend[7] = 0 -> counter stays 0.
- i_enable = 0 mid-run with pend[4] = 1 -> IDLE with o_flush = 1; retire rd = 4 in IDLE -> o_busy falls. Asserting reset during FLUSH -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/rice_core_hazard_controller_if.sv
// ============================================================================
// Module   : rice_core_hazard_controller_if
// Brief    : Pipeline-side bundle of the hazard controller (issue, retire,
//            branch in; stall, flush, redirect, busy out).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface rice_core_hazard_controller_if #(
    parameter int XLEN = 32
);
    logic            i_enable;
    logic            i_issue_valid;
    logic [4:0]      i_issue_rs1;
    logic [4:0]      i_issue_rs2;
    logic [4:0]      i_issue_rd;
    logic            i_retire_valid;
    logic [4:0]      i_retire_rd;
    logic            i_branch_valid;
    logic [XLEN-1:0] i_branch_target;
    logic            o_stall;
    logic            o_flush;
    logic            o_redirect_valid;
    logic [XLEN-1:0] o_redirect_pc;
    logic            o_busy;

    modport master (
        output i_enable, i_issue_valid, i_issue_rs1, i_issue_rs2, i_issue_rd,
        output i_retire_valid, i_retire_rd, i_branch_valid, i_branch_target,
        input  o_stall, o_flush, o_redirect_valid, o_redirect_pc, o_busy
    );

    modport slave (
        input  i_enable, i_issue_valid, i_issue_rs1, i_issue_rs2, i_issue_rd,
        input  i_retire_valid, i_retire_rd, i_branch_valid, i_branch_target,
        output o_stall, o_flush, o_redirect_valid, o_redirect_pc, o_busy
    );
endinterface

`default_nettype wire

// File: rtl/rice_core_hazard_controller.sv
// ============================================================================
// Module   : rice_core_hazard_controller
// Brief    : Scoreboard RAW stall, multi-cycle branch flush sequencing and
//            disable hold for the IF/ID/EX pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rice_core_hazard_controller #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int PEND_W       = 2
) (
    input  wire logic                    i_clk,
    input  wire logic                    i_rst_n,
    rice_core_hazard_controller_if.slave bus
);

    localparam logic [PEND_W-1:0] c_PEND_MAX  = '1;
    localparam logic [3:0]        c_FCNT_INIT = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        fcnt_q, fcnt_d;
    logic              redir_valid_q, redir_valid_d;
    logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
    logic              busy_q;
    logic [PEND_W-1:0] pend_q [32];
    logic [PEND_W-1:0] pend_d [32];

    logic w_run;
    logic w_flush;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_rd_full;
    logic w_stall;
    logic w_accept;
    logic w_any_pend;

    assign w_run     = (state_q == ST_RUN);
    assign w_rs1_hit = (bus.i_issue_rs1 != 5'd0) && (pend_q[bus.i_issue_rs1] != '0);
    assign w_rs2_hit = (bus.i_issue_rs2 != 5'd0) && (pend_q[bus.i_issue_rs2] != '0);
    assign w_rd_full = (bus.i_issue_rd  != 5'd0) && (pend_q[bus.i_issue_rd] == c_PEND_MAX);
    assign w_stall   = w_run && bus.i_issue_valid && (w_rs1_hit || w_rs2_hit || w_rd_full);
    // A branch in the same cycle kills the instruction in ID, so it must not be counted.
    assign w_accept  = w_run && bus.i_issue_valid && !w_stall && !bus.i_branch_valid;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pend_d[gi] = '0;
            end else begin : g_reg
                logic w_inc;
                logic w_dec;
                assign w_inc = w_accept && (bus.i_issue_rd == 5'(gi));
                // Retire to an empty counter is dropped rather than wrapping.
                assign w_dec = bus.i_retire_valid && (bus.i_retire_rd == 5'(gi))
                               && (pend_q[gi] != '0);
                assign pend_d[gi] = (w_inc && !w_dec) ? pend_q[gi] + 1'b1 :
                                    (!w_inc && w_dec) ? pend_q[gi] - 1'b1 :
                                                        pend_q[gi];
            end
        end
    endgenerate

    always_comb begin
        w_any_pend = 1'b0;
        for (int i = 1; i < 32; i++) begin
            w_any_pend = w_any_pend | (pend_q[i] != '0);
        end
    end

    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;
        w_flush       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                w_flush = 1'b0;
                if (!bus.i_enable) begin
                    state_d = ST_IDLE;
                end else if (bus.i_branch_valid) begin
                    state_d       = ST_FLUSH;
                    fcnt_d        = c_FCNT_INIT;
                    redir_valid_d = 1'b1;
                    redir_pc_d    = bus.i_branch_target;
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == 4'd0) begin
                    state_d = bus.i_enable ? ST_RUN : ST_IDLE;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            fcnt_q        <= 4'd0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            busy_q        <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            busy_q        <= w_any_pend;
            for (int i = 0; i < 32; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

    assign bus.o_stall          = w_stall;
    assign bus.o_flush          = w_flush;
    assign bus.o_redirect_valid = redir_valid_q;
    assign bus.o_redirect_pc    = redir_pc_q;
    assign bus.o_busy           = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_rice_core_hazard_controller.sv
// ============================================================================
// Module   : tb_rice_core_hazard_controller
// Brief    : Directed and random stimulus against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rice_core_hazard_controller;

    localparam int XLEN = 32;
    localparam int FC   = 2;
    localparam int PW   = 2;
    localparam int MAXP = (1 << PW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rice_core_hazard_controller_if #(.XLEN(XLEN)) bus ();

    rice_core_hazard_controller #(
        .XLEN(XLEN), .FLUSH_CYCLES(FC), .PEND_W(PW)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: mode 0=idle 1=run 2=flush; flush_left = flush cycles still to come.
    int          mode;
    int          flush_left;
    int          cnt [32];
    bit          busy_m;
    logic [31:0] mpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_stall();
        bit hz;
        hz = ((bus.i_issue_rs1 != 0) && (cnt[bus.i_issue_rs1] > 0)) ||
             ((bus.i_issue_rs2 != 0) && (cnt[bus.i_issue_rs2] > 0)) ||
             ((bus.i_issue_rd  != 0) && (cnt[bus.i_issue_rd] == MAXP));
        return (mode == 1) && bus.i_issue_valid && hz;
    endfunction

    task automatic model_reset();
        mode = 0; flush_left = 0; busy_m = 0; mpc = '0;
        for (int i = 0; i < 32; i++) cnt[i] = 0;
    endtask

    task automatic check_model();
        chk("flush",    {31'd0, bus.o_flush},          {31'd0, mode != 2'd1 ? 1'b1 : 1'b0});
        chk("stall",    {31'd0, bus.o_stall},          {31'd0, model_stall()});
        chk("redir_v",  {31'd0, bus.o_redirect_valid}, {31'd0, (mode == 2 && flush_left == FC) ? 1'b1 : 1'b0});
        chk("redir_pc", bus.o_redirect_pc,             mpc);
        chk("busy",     {31'd0, bus.o_busy},           {31'd0, busy_m});
    endtask

    task automatic model_edge();
        bit st, acc, rok, any;
        st  = model_stall();
        any = 0;
        for (int i = 0; i < 32; i++) if (cnt[i] != 0) any = 1;
        acc = (mode == 1) && bus.i_issue_valid && !st && !bus.i_branch_valid;
        rok = bus.i_retire_valid && (bus.i_retire_rd != 0) && (cnt[bus.i_retire_rd] > 0);
        if (acc && bus.i_issue_rd != 0) cnt[bus.i_issue_rd]++;
        if (rok) cnt[bus.i_retire_rd]--;
        busy_m = any;
        case (mode)
            0: if (bus.i_enable) mode = 1;
            1: begin
                if (!bus.i_enable) mode = 0;
                else if (bus.i_branch_valid) begin
                    mode = 2; flush_left = FC; mpc = bus.i_branch_target;
                end
            end
            default: begin
                flush_left--;
                if (flush_left == 0) mode = bus.i_enable ? 1 : 0;
            end
        endcase
    endtask

    task automatic drive(input bit en, input bit iv, input int rs1, input int rs2, input int rd,
                         input bit rv, input int rrd, input bit br, input logic [31:0] tgt);
        bus.i_enable        = en;
        bus.i_issue_valid   = iv;
        bus.i_issue_rs1     = 5'(rs1);
        bus.i_issue_rs2     = 5'(rs2);
        bus.i_issue_rd      = 5'(rd);
        bus.i_retire_valid  = rv;
        bus.i_retire_rd     = 5'(rrd);
        bus.i_branch_valid  = br;
        bus.i_branch_target = tgt;
    endtask

    task automatic tick_check();
        @(negedge clk);
        check_model();
    endtask

    task automatic tick_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        tick_check();
        tick_edge();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_flush", {31'd0, bus.o_flush}, 32'd1);
        chk("rst_stall", {31'd0, bus.o_stall}, 32'd0);
        chk("rst_rv",    {31'd0, bus.o_redirect_valid}, 32'd0);
        chk("rst_pc",    bus.o_redirect_pc, 32'd0);
        chk("rst_busy",  {31'd0, bus.o_busy}, 32'd0);
        rst_n = 1'b1;
        tick_edge();

        // Enable: flush held through the enable cycle, low afterwards.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        tick_check(); chk("en_cycle_flush", {31'd0, bus.o_flush}, 32'd1); tick_edge();
        tick_check(); chk("run_flush", {31'd0, bus.o_flush}, 32'd0);
        chk("run_busy", {31'd0, bus.o_busy}, 32'd0); tick_edge();

        // RAW on x5, stall holds through the retire cycle.
        drive(1, 1, 0, 0, 5, 0, 0, 0, 32'h0);
        tick_check(); chk("x5_issue", {31'd0, bus.o_stall}, 32'd0); tick_edge();
        drive(1, 1, 5, 0, 0, 0, 0, 0, 32'h0);
        tick_check(); chk("x5_raw", {31'd0, bus.o_stall}, 32'd1); tick_edge();
        drive(1, 1, 5, 0, 0, 1, 5, 0, 32'h0);
        tick_check(); chk("x5_ret_same", {31'd0, bus.o_stall}, 32'd1); tick_edge();
        drive(1, 1, 5, 0, 0, 0, 0, 0, 32'h0);
        tick_check(); chk("x5_release", {31'd0, bus.o_stall}, 32'd0); tick_edge();

        // Fill x3 to max, then full stall; simultaneous issue+retire keeps count.
        drive(1, 1, 0, 0, 3, 0, 0, 0, 32'h0);
        repeat (3) begin tick_check(); chk("x3_fill", {31'd0, bus.o_stall}, 32'd0); tick_edge(); end
        tick_check(); chk("x3_full", {31'd0, bus.o_stall}, 32'd1); tick_edge();
        drive(1, 0, 0, 0, 0, 1, 3, 0, 32'h0); step();
        drive(1, 1, 0, 0, 3, 1, 3, 0, 32'h0);
        tick_check(); chk("x3_iss_ret", {31'd0, bus.o_stall}, 32'd0); tick_edge();
        drive(1, 1, 0, 0, 3, 0, 0, 0, 32'h0); step();
        tick_check(); chk("x3_net_zero", {31'd0, bus.o_stall}, 32'd1); tick_edge();
        drive(1, 0, 0, 0, 0, 1, 3, 0, 32'h0);
        repeat (3) step();

        // x0 never hazards; retire to empty x7 stays empty.
        drive(1, 1, 0, 0, 0, 1, 7, 0, 32'h0);
        tick_check(); chk("x0_nostall", {31'd0, bus.o_stall}, 32'd0); tick_edge();
        drive(1, 1, 7, 0, 0, 0, 0, 0, 32'h0);
        tick_check(); chk("x7_empty", {31'd0, bus.o_stall}, 32'd0); tick_edge();

        // Branch: two flush cycles, strobe only in the first, second branch ignored.
        drive(1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0100);
        tick_check(); chk("br_run", {31'd0, bus.o_flush}, 32'd0); tick_edge();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0200);
        tick_check(); chk("fl1_flush", {31'd0, bus.o_flush}, 32'd1);
        chk("fl1_rv", {31'd0, bus.o_redirect_valid}, 32'd1);
        chk("fl1_pc", bus.o_redirect_pc, 32'h100); tick_edge();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        tick_check(); chk("fl2_flush", {31'd0, bus.o_flush}, 32'd1);
        chk("fl2_rv", {31'd0, bus.o_redirect_valid}, 32'd0); tick_edge();
        tick_check(); chk("fl_done", {31'd0, bus.o_flush}, 32'd0);
        chk("fl_pc_hold", bus.o_redirect_pc, 32'h100); tick_edge();

        // Disable with x4 in flight, drain in IDLE.
        drive(1, 1, 0, 0, 4, 0, 0, 0, 32'h0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0); step();
        drive(0, 0, 0, 0, 0, 1, 4, 0, 32'h0);
        tick_check(); chk("idle_flush", {31'd0, bus.o_flush}, 32'd1);
        chk("idle_busy", {31'd0, bus.o_busy}, 32'd1); tick_edge();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        step(); step();
        tick_check(); chk("drain_busy", {31'd0, bus.o_busy}, 32'd0); tick_edge();

        // Asynchronous reset in the middle of a flush.
        drive(1, 1, 0, 0, 2, 0, 0, 0, 32'h0); step(); step();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0abc); step();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        tick_check();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_flush", {31'd0, bus.o_flush}, 32'd1);
        chk("arst_rv",    {31'd0, bus.o_redirect_valid}, 32'd0);
        chk("arst_pc",    bus.o_redirect_pc, 32'd0);
        chk("arst_busy",  {31'd0, bus.o_busy}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick_edge();
        drive(1, 1, 0, 0, 2, 0, 0, 0, 32'h0);
        step();
        tick_check(); chk("arst_cnt_clr", {31'd0, bus.o_busy}, 32'd0); tick_edge();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 25) != 0, ($urandom % 4) != 0,
                  $urandom % 8, $urandom % 8, $urandom % 8,
                  ($urandom % 3) == 0, $urandom % 8,
                  ($urandom % 10) == 0, $urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
